mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, word address width.
REQ-002 SHALL have parameter LINE_W, default 64, cache line width (4 x 16-bit words).
REQ-003 SHALL have parameter CNT_W, default 16, stall-cycle counter width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_miss  input  1  I-cache miss pending.
REQ-007 SHALL have port i_addr  input  ADDR_W  I-cache miss word address.
REQ-008 SHALL have port d_miss  input  1  D-cache miss pending.
REQ-009 SHALL have port d_addr  input  ADDR_W  D-cache miss word address.
REQ-010 SHALL have port d_dirty  input  1  D-cache victim line dirty.
REQ-011 SHALL have port d_wb_addr  input  ADDR_W  victim line word address.
REQ-012 SHALL have port d_wb_data  input  LINE_W  victim line data.
REQ-013 SHALL have port mem_re  output  1  memory line read request.
REQ-014 SHALL have port mem_we  output  1  memory line write request.
REQ-015 SHALL have port mem_addr  output  ADDR_W-2  memory line address.
REQ-016 SHALL have port mem_wdata  output  LINE_W  memory write data.
REQ-017 SHALL have port mem_rdata  input  LINE_W  memory read data, valid with mem_rdy.
REQ-018 SHALL have port mem_rdy  input  1  one-cycle completion pulse for the current request.
REQ-019 SHALL have port i_fill  output  1  one-cycle I-cache line write strobe.
REQ-020 SHALL have port d_fill  output  1  one-cycle D-cache line write strobe.
REQ-021 SHALL have port fill_data  output  LINE_W  registered fill line.
REQ-022 SHALL have port cache_stall  output  1  stall request to hazard control.
REQ-023 SHALL have port stall_cycles  output  CNT_W  saturating count of cycles with cache_stall high.

Function
REQ-024 SHALL implement FSM states IDLE, WB, DFILL, IFILL, RESP, all registered on rising clk.
REQ-025 IDLE: d_miss&d_dirty -> WB; d_miss&!d_dirty -> DFILL; else i_miss -> IFILL; else stay; D-side SHALL win over simultaneous I-side.
REQ-026 On leaving IDLE the block SHALL latch the line address (addr[ADDR_W-1:2]) and, for WB, d_wb_data; later changes to address/data inputs SHALL be ignored until IDLE.
REQ-027 WB: mem_we=1, mem_addr=latched victim line, mem_wdata=latched data; on mem_rdy latch d_addr line, go DFILL.
REQ-028 DFILL/IFILL: mem_re=1 with latched line address; on mem_rdy capture mem_rdata into fill_data, go RESP.
REQ-029 RESP: exactly one of d_fill/i_fill SHALL be 1 for this single cycle, matching the serviced side; next state IDLE.
REQ-030 mem_re and mem_we SHALL never be high together; both SHALL be 0 in IDLE and RESP.
REQ-031 mem_rdy in IDLE or RESP SHALL be ignored.
REQ-032 cache_stall SHALL be combinational: (state!=IDLE) | i_miss | d_miss.
REQ-033 Minimum miss service: clean miss with mem_rdy on first request cycle SHALL give fill strobe 2 cycles after miss first sampled in IDLE.
REQ-034 A pending I-miss during D-service SHALL be serviced from the IDLE cycle after RESP.
REQ-035 stall_cycles SHALL increment each cycle cache_stall=1 and hold at all-ones (no wrap).
REQ-036 fill_data SHALL hold its value outside RESP.

Reset
REQ-037 rst_n low SHALL immediately force state=IDLE; mem_re, mem_we, i_fill, d_fill=0; mem_addr, mem_wdata, fill_data, stall_cycles=0.
REQ-038 Reset mid-transaction SHALL abandon the request with no fill strobe; a late mem_rdy after release SHALL be ignored per REQ-031.

Structure
REQ-039 State enum, LINE_W, ADDR_W and the line-offset width (2) SHALL live in the shared CPU package.
REQ-040 The saturating counter SHALL be a sub-module named sat_counter (parameter CNT_W; ports clk, rst_n, inc, count).

Verification
REQ-041 Clean D-miss, d_addr=0x1234, mem_rdy 3 cycles after mem_re -> mem_addr=0x048D, d_fill one cycle, fill_data=mem_rdata, cache_stall high throughout.
REQ-042 Dirty D-miss, d_wb_addr=0x0040, d_addr=0x0080 -> mem_we with mem_addr=0x0010 then mem_re with mem_addr=0x0020; never both high.
REQ-043 i_miss and d_miss asserted same cycle -> D serviced first, i_fill strobe exactly after d_fill RESP + IDLE + IFILL sequence.
REQ-044 rst_n low during DFILL, mem_rdy pulse after release -> no fill strobe, state IDLE, all outputs zero.
REQ-045 CNT_W=4, cache_stall held 20 cycles -> stall_cycles reaches 0xF and stays 0xF.
REQ-046 mem_rdy pulsed while IDLE with no misses -> no state change, no strobes, cache_stall=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: memory geometry and arbiter state encoding.
// Used by the line-fill arbiter and the interface that carries its memory bus.
package mem_arbiter_pkg;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 64;
  localparam int OFS_W  = 2;

  typedef enum logic [2:0] {IDLE, WB, DFILL, IFILL, RESP} state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Line-granular memory bus between the arbiter (master) and backing memory (slave).
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = mem_arbiter_pkg::ADDR_W,
  parameter int LINE_W = mem_arbiter_pkg::LINE_W
) ();
  logic                    mem_re;
  logic                    mem_we;
  logic [ADDR_W-OFS_W-1:0] mem_addr;
  logic [LINE_W-1:0]       mem_wdata;
  logic [LINE_W-1:0]       mem_rdata;
  logic                    mem_rdy;

  modport master (output mem_re, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_rdy);
  modport slave  (input  mem_re, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_rdy);
endinterface

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                   count <= '0;
    else if (inc && count != '1)  count <= count + 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I/D cache line misses onto one memory port, with dirty-victim
// writeback ahead of the D fill. D-side wins ties.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = mem_arbiter_pkg::ADDR_W,
  parameter int LINE_W = mem_arbiter_pkg::LINE_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_dirty,
  input  logic [ADDR_W-1:0] d_wb_addr,
  input  logic [LINE_W-1:0] d_wb_data,
  mem_arbiter_if.master     mem,
  output logic              i_fill,
  output logic              d_fill,
  output logic [LINE_W-1:0] fill_data,
  output logic              cache_stall,
  output logic [CNT_W-1:0]  stall_cycles
);
  localparam int LW = ADDR_W - OFS_W;

  state_t          state, nxt;
  logic [LW-1:0]   line_q, dline_q;
  logic [LINE_W-1:0] wdata_q, fill_q;
  logic            side_d_q;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:        if (d_miss)      nxt = d_dirty ? WB : DFILL;
                   else if (i_miss) nxt = IFILL;
      WB:          if (mem.mem_rdy) nxt = DFILL;
      DFILL, IFILL: if (mem.mem_rdy) nxt = RESP;
      RESP:        nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end

  // Both line addresses are captured on IDLE exit so the post-writeback
  // fill uses the miss address as it stood when service began.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      line_q   <= '0;
      dline_q  <= '0;
      wdata_q  <= '0;
      fill_q   <= '0;
      side_d_q <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE:
          if (d_miss) begin
            side_d_q <= 1'b1;
            dline_q  <= d_addr[ADDR_W-1:OFS_W];
            if (d_dirty) begin
              line_q  <= d_wb_addr[ADDR_W-1:OFS_W];
              wdata_q <= d_wb_data;
            end else begin
              line_q  <= d_addr[ADDR_W-1:OFS_W];
            end
          end else if (i_miss) begin
            side_d_q <= 1'b0;
            line_q   <= i_addr[ADDR_W-1:OFS_W];
          end
        WB:           if (mem.mem_rdy) line_q <= dline_q;
        DFILL, IFILL: if (mem.mem_rdy) fill_q <= mem.mem_rdata;
        default: ;
      endcase
    end
  end

  assign mem.mem_we    = (state == WB);
  assign mem.mem_re    = (state == DFILL) || (state == IFILL);
  assign mem.mem_addr  = line_q;
  assign mem.mem_wdata = wdata_q;

  assign d_fill      = (state == RESP) &&  side_d_q;
  assign i_fill      = (state == RESP) && !side_d_q;
  assign fill_data   = fill_q;
  assign cache_stall = (state != IDLE) || i_miss || d_miss;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cache_stall),
    .count (stall_cycles)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a transaction-queue model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_miss = 0, d_miss = 0, d_dirty = 0, mem_rdy = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wb_addr = 0;
  logic [63:0] d_wb_data = 0, mem_rdata = 0;

  logic        i_fill, d_fill, cache_stall, i_fill4, d_fill4, cache_stall4;
  logic [63:0] fill_data, fill_data4;
  logic [15:0] stall_cycles;
  logic [3:0]  stall_cycles4;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .LINE_W(64)) mif ();
  mem_arbiter_if #(.ADDR_W(16), .LINE_W(64)) mif4 ();
  assign mif.mem_rdy    = mem_rdy;
  assign mif.mem_rdata  = mem_rdata;
  assign mif4.mem_rdy   = mem_rdy;
  assign mif4.mem_rdata = mem_rdata;

  mem_arbiter #(.ADDR_W(16), .LINE_W(64), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_addr(d_addr), .d_dirty(d_dirty),
    .d_wb_addr(d_wb_addr), .d_wb_data(d_wb_data), .mem(mif.master),
    .i_fill(i_fill), .d_fill(d_fill), .fill_data(fill_data),
    .cache_stall(cache_stall), .stall_cycles(stall_cycles));

  mem_arbiter #(.ADDR_W(16), .LINE_W(64), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_addr(d_addr), .d_dirty(d_dirty),
    .d_wb_addr(d_wb_addr), .d_wb_data(d_wb_data), .mem(mif4.master),
    .i_fill(i_fill4), .d_fill(d_fill4), .fill_data(fill_data4),
    .cache_stall(cache_stall4), .stall_cycles(stall_cycles4));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: queue of outstanding memory ops for the miss in service, plus a
  // pending one-cycle response strobe.
  typedef struct {bit wr; logic [13:0] line; logic [63:0] data;} op_t;
  op_t         ops[$];
  bit          m_resp, m_side_d;
  logic [63:0] m_fill;
  int          m_cnt, m_cnt4;

  task automatic model_reset();
    ops.delete();
    m_resp = 0; m_side_d = 0; m_fill = '0; m_cnt = 0; m_cnt4 = 0;
  endtask

  function automatic bit mem_busy();
    return (ops.size() > 0) && !m_resp;
  endfunction

  // Called at a negedge after inputs for this cycle are driven; checks the
  // cycle, advances the model across the next posedge, returns at next negedge.
  task automatic tick();
    bit rq, stall_e;
    op_t o, w, r;
    #1;
    rq = mem_busy();
    if (rq) o = ops[0];
    stall_e = m_resp || rq || i_miss || d_miss;
    chk("mem_re", 64'(mif.mem_re), 64'(rq && !o.wr));
    chk("mem_we", 64'(mif.mem_we), 64'(rq && o.wr));
    chk("re_we_excl", 64'(mif.mem_re & mif.mem_we), 64'(0));
    if (rq) chk("mem_addr", 64'(mif.mem_addr), 64'(o.line));
    if (rq && o.wr) chk("mem_wdata", mif.mem_wdata, o.data);
    chk("d_fill", 64'(d_fill), 64'(m_resp && m_side_d));
    chk("i_fill", 64'(i_fill), 64'(m_resp && !m_side_d));
    chk("fill_data", fill_data, m_fill);
    chk("cache_stall", 64'(cache_stall), 64'(stall_e));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
    chk("stall_cycles4", 64'(stall_cycles4), 64'(m_cnt4));
    if (stall_e) begin
      if (m_cnt  < 16'hFFFF) m_cnt++;
      if (m_cnt4 < 15)       m_cnt4++;
    end
    if (m_resp) m_resp = 0;
    else if (rq) begin
      if (mem_rdy) begin
        if (!o.wr) begin m_fill = mem_rdata; m_resp = 1; end
        void'(ops.pop_front());
      end
    end else if (d_miss) begin
      m_side_d = 1;
      if (d_dirty) begin
        w.wr = 1; w.line = d_wb_addr[15:2]; w.data = d_wb_data; ops.push_back(w);
      end
      r.wr = 0; r.line = d_addr[15:2]; r.data = '0; ops.push_back(r);
    end else if (i_miss) begin
      m_side_d = 0;
      r.wr = 0; r.line = i_addr[15:2]; r.data = '0; ops.push_back(r);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_miss = 0; d_miss = 0; d_dirty = 0; mem_rdy = 0;
  endtask

  initial begin
    bit just_i, just_d;
    model_reset();
    #12;
    chk("rst_stall_cycles", 64'(stall_cycles), 64'(0));
    chk("rst_mem_re", 64'(mif.mem_re), 64'(0));
    chk("rst_fill_data", fill_data, 64'(0));
    @(negedge clk); rst_n = 1;

    // mem_rdy while idle with no misses
    mem_rdy = 1; tick();
    chk("idle_rdy_stall", 64'(cache_stall), 64'(0));
    chk("idle_rdy_re", 64'(mif.mem_re), 64'(0));
    mem_rdy = 0; tick();

    // clean D-miss, mem_rdy 3 cycles after mem_re
    d_miss = 1; d_addr = 16'h1234; d_dirty = 0; tick();
    chk("dmiss_re", 64'(mif.mem_re), 64'(1));
    chk("dmiss_addr", 64'(mif.mem_addr), 64'h048D);
    repeat (3) tick();
    mem_rdy = 1; mem_rdata = 64'hDEAD_BEEF_0123_4567; tick();
    mem_rdy = 0;
    chk("dmiss_dfill", 64'(d_fill), 64'(1));
    chk("dmiss_data", fill_data, 64'hDEAD_BEEF_0123_4567);
    chk("dmiss_stall", 64'(cache_stall), 64'(1));
    d_miss = 0; tick();
    chk("dmiss_dfill_off", 64'(d_fill), 64'(0));
    chk("dmiss_data_hold", fill_data, 64'hDEAD_BEEF_0123_4567);
    tick();

    // minimum latency: I-miss, mem_rdy on first request cycle
    i_miss = 1; i_addr = 16'h0F0C; tick();
    mem_rdy = 1; mem_rdata = 64'h1111_2222_3333_4444; i_addr = 16'hFFFF; tick();
    mem_rdy = 0;
    chk("minlat_ifill", 64'(i_fill), 64'(1));
    i_miss = 0; tick();

    // dirty D-miss: writeback then fill
    d_miss = 1; d_dirty = 1; d_wb_addr = 16'h0040; d_addr = 16'h0080;
    d_wb_data = 64'hA5A5_5A5A_0F0F_F0F0; tick();
    chk("wb_we", 64'(mif.mem_we), 64'(1));
    chk("wb_re", 64'(mif.mem_re), 64'(0));
    chk("wb_addr", 64'(mif.mem_addr), 64'h0010);
    chk("wb_data", mif.mem_wdata, 64'hA5A5_5A5A_0F0F_F0F0);
    mem_rdy = 1; d_wb_addr = 16'h7777; tick();
    chk("wbfill_re", 64'(mif.mem_re), 64'(1));
    chk("wbfill_we", 64'(mif.mem_we), 64'(0));
    chk("wbfill_addr", 64'(mif.mem_addr), 64'h0020);
    tick();
    mem_rdy = 0; d_miss = 0; d_dirty = 0; tick();

    // simultaneous I and D: D first, then RESP + IDLE + IFILL + RESP
    d_miss = 1; d_addr = 16'h2000; i_miss = 1; i_addr = 16'h3000; tick();
    chk("tie_d_first", 64'(mif.mem_addr), 64'h0800);
    mem_rdy = 1; tick();
    mem_rdy = 0;
    chk("tie_dfill", 64'(d_fill), 64'(1));
    d_miss = 0; tick();
    chk("tie_idle_ifill0", 64'(i_fill), 64'(0));
    tick();
    chk("tie_iaddr", 64'(mif.mem_addr), 64'h0C00);
    mem_rdy = 1; tick();
    mem_rdy = 0;
    chk("tie_ifill", 64'(i_fill), 64'(1));
    i_miss = 0; tick();

    // reset during DFILL, late mem_rdy after release
    d_miss = 1; d_addr = 16'h4444; tick();
    chk("rstmid_re", 64'(mif.mem_re), 64'(1));
    #2 rst_n = 0; idle_inputs();
    #1;
    chk("rstmid_re0", 64'(mif.mem_re), 64'(0));
    chk("rstmid_addr0", 64'(mif.mem_addr), 64'(0));
    chk("rstmid_fill0", fill_data, 64'(0));
    chk("rstmid_cnt0", 64'(stall_cycles), 64'(0));
    model_reset();
    @(negedge clk); rst_n = 1;
    mem_rdy = 1; tick();
    mem_rdy = 0;
    chk("rstmid_nofill", 64'(d_fill | i_fill), 64'(0));
    chk("rstmid_idle_re", 64'(mif.mem_re | mif.mem_we), 64'(0));
    tick();

    // randomized traffic
    just_i = 0; just_d = 0;
    for (int c = 0; c < 2000; c++) begin
      just_i = 0; just_d = 0;
      if (m_resp &&  m_side_d) begin d_miss = 0; just_d = 1; end
      if (m_resp && !m_side_d) begin i_miss = 0; just_i = 1; end
      if (!i_miss && !just_i && $urandom_range(3) == 0) begin
        i_miss = 1; i_addr = 16'($urandom);
      end else if ($urandom_range(3) == 0) i_addr = 16'($urandom);
      if (!d_miss) begin
        d_addr = 16'($urandom);
        if (!just_d && $urandom_range(3) == 0) begin
          d_miss = 1; d_dirty = 1'($urandom);
        end
      end
      if ($urandom_range(2) == 0) d_wb_addr = 16'($urandom);
      if ($urandom_range(2) == 0) d_wb_data = {$urandom, $urandom};
      mem_rdata = {$urandom, $urandom};
      mem_rdy = mem_busy() ? ($urandom_range(2) == 0) : ($urandom_range(5) == 0);
      tick();
    end
    chk("sat4_final", 64'(stall_cycles4), 64'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
